// File: rtl/mem_router.sv
// Single-outstanding request router: decodes a 32-bit address onto ROM, RAM, frame-buffer
// and IO ports, splits wide RAM accesses into beats and returns one response per request.
module mem_router #(
    parameter int          RAM_BYTES    = 1,
    parameter int          RAM_LAT      = 2,
    parameter int          ROM_LAT      = 2,
    parameter int          FB_LAT       = 2,
    parameter logic [27:0] FB_SWAP_ADDR = 28'hFFFFFFF
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   req_valid_in,
    output logic                   req_ready_out,
    input  logic                   req_write_in,
    input  logic [31:0]            req_addr_in,
    input  logic [31:0]            req_wdata_in,
    input  logic [1:0]             req_width_in,
    output logic                   rsp_valid_out,
    output logic [31:0]            rsp_rdata_out,
    output logic                   rsp_err_out,
    output logic [27:0]            ram_addr_out,
    output logic                   ram_we_out,
    output logic [RAM_BYTES-1:0]   ram_be_out,
    output logic [8*RAM_BYTES-1:0] ram_wdata_out,
    input  logic [8*RAM_BYTES-1:0] ram_rdata_in,
    output logic [27:0]            rom_addr_out,
    input  logic [31:0]            rom_rdata_in,
    output logic [27:0]            fb_addr_out,
    output logic                   fb_we_out,
    output logic                   fb_swap_out,
    output logic [15:0]            fb_wdata_out,
    input  logic [15:0]            fb_rdata_in,
    output logic [27:0]            io_addr_out,
    output logic                   io_we_out,
    output logic [31:0]            io_wdata_out,
    input  logic [31:0]            io_rdata_in
);

    localparam int          RB_LOG = (RAM_BYTES == 4) ? 2 : (RAM_BYTES == 2) ? 1 : 0;
    localparam int          RW     = 8 * RAM_BYTES;
    localparam logic [2:0]  RBB    = 3'(RAM_BYTES);
    localparam logic [1:0]  T_ROM  = 2'd0;
    localparam logic [1:0]  T_RAM  = 2'd1;
    localparam logic [1:0]  T_FB   = 2'd2;
    localparam logic [1:0]  T_IO   = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  tgt_q, tgt_d;
    logic [27:0] off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  width_q, width_d;
    logic        err_q, err_d;
    logic [1:0]  beat_q, beat_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] rd_q, rd_d;

    logic [27:0] in_off;
    logic [1:0]  in_tgt;
    logic        in_err;
    logic [2:0]  size;
    logic        narrow;
    logic [1:0]  last_beat;
    logic [3:0]  lat;
    logic [1:0]  lane;
    logic [4:0]  lane_sh;
    logic [4:0]  beat_sh;
    logic [3:0]  smask4;
    logic [31:0] mask32;
    logic [31:0] cap;
    logic        beat_end;
    logic        act, issue_wr;

    assign in_off = req_addr_in[27:0];
    assign in_tgt = req_addr_in[29:28];
    assign in_err = (req_width_in == 2'd3)
                 || (req_width_in == 2'd1 && in_off[0])
                 || (req_width_in == 2'd2 && in_off[1:0] != 2'b00)
                 || (req_write_in && in_tgt == T_ROM)
                 || (req_addr_in[31:30] != 2'b00)
                 || (in_tgt == T_FB && req_width_in != 2'd1);

    assign size      = 3'd1 << width_q;
    assign narrow    = (tgt_q == T_RAM) && (size < RBB);
    assign last_beat = (tgt_q == T_RAM && size > RBB) ? 2'((size >> RB_LOG) - 3'd1) : 2'd0;
    assign lane      = off_q[1:0] & 2'(RAM_BYTES - 1);
    assign lane_sh   = {lane, 3'b000};
    assign beat_sh   = 5'(beat_q) << (3 + RB_LOG);

    always_comb begin
        lat    = 4'd0;
        smask4 = 4'b1111;
        mask32 = 32'hFFFF_FFFF;
        case (tgt_q)
            T_ROM:   lat = 4'(ROM_LAT);
            T_RAM:   lat = 4'(RAM_LAT);
            T_FB:    lat = 4'(FB_LAT);
            default: lat = 4'd0;
        endcase
        case (width_q)
            2'd0:    begin smask4 = 4'b0001; mask32 = 32'h0000_00FF; end
            2'd1:    begin smask4 = 4'b0011; mask32 = 32'h0000_FFFF; end
            default: begin smask4 = 4'b1111; mask32 = 32'hFFFF_FFFF; end
        endcase
    end

    // Wide RAM reads assemble beat by beat little-endian; narrow ones pull their lanes down to bit 0.
    always_comb begin
        cap = 32'h0;
        case (tgt_q)
            T_ROM:   cap = rom_rdata_in >> {off_q[1:0], 3'b000};
            T_RAM:   cap = narrow ? (32'(ram_rdata_in) >> lane_sh)
                                  : (rd_q | (32'(ram_rdata_in) << beat_sh));
            T_FB:    cap = {16'h0000, fb_rdata_in};
            default: cap = io_rdata_in;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        tgt_d    = tgt_q;
        off_d    = off_q;
        wdata_d  = wdata_q;
        width_d  = width_q;
        err_d    = err_q;
        beat_d   = beat_q;
        wcnt_d   = wcnt_q;
        rd_d     = rd_q;
        beat_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_in) begin
                    write_d = req_write_in;
                    tgt_d   = in_tgt;
                    off_d   = in_off;
                    wdata_d = req_wdata_in;
                    width_d = req_width_in;
                    err_d   = in_err;
                    beat_d  = 2'd0;
                    wcnt_d  = 4'd0;
                    rd_d    = 32'h0;
                    state_d = in_err ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (write_q || lat == 4'd0) begin
                    beat_end = 1'b1;
                end else begin
                    state_d = WAIT;
                    wcnt_d  = 4'd0;
                end
            end
            WAIT: begin
                if (wcnt_q == 4'(lat - 4'd1)) beat_end = 1'b1;
                else                         wcnt_d   = wcnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
        if (beat_end) begin
            if (!write_q) rd_d = cap;
            if (beat_q == last_beat) begin
                state_d = RESP;
            end else begin
                state_d = ISSUE;
                beat_d  = beat_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            tgt_q   <= 2'd0;
            off_q   <= 28'h0;
            wdata_q <= 32'h0;
            width_q <= 2'd0;
            err_q   <= 1'b0;
            beat_q  <= 2'd0;
            wcnt_q  <= 4'd0;
            rd_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            tgt_q   <= tgt_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            width_q <= width_d;
            err_q   <= err_d;
            beat_q  <= beat_d;
            wcnt_q  <= wcnt_d;
            rd_q    <= rd_d;
        end
    end

    // Port outputs are gated by state so reset (IDLE) forces them all to zero at once.
    assign act      = (state_q == ISSUE) || (state_q == WAIT);
    assign issue_wr = (state_q == ISSUE) && write_q;

    assign req_ready_out = (state_q == IDLE);
    assign rsp_valid_out = (state_q == RESP);
    assign rsp_err_out   = (state_q == RESP) && err_q;
    assign rsp_rdata_out = (state_q == RESP && !err_q) ? (rd_q & mask32) : 32'h0;

    assign ram_addr_out  = (act && tgt_q == T_RAM) ? ((off_q >> RB_LOG) + 28'(beat_q)) : 28'h0;
    assign ram_we_out    = issue_wr && tgt_q == T_RAM;
    assign ram_be_out    = (act && tgt_q == T_RAM)
                         ? RAM_BYTES'(narrow ? (smask4 << lane) : 4'hF) : '0;
    assign ram_wdata_out = (act && tgt_q == T_RAM)
                         ? RW'(narrow ? (wdata_q << lane_sh) : (wdata_q >> beat_sh)) : '0;

    assign rom_addr_out  = (act && tgt_q == T_ROM) ? off_q : 28'h0;

    assign fb_addr_out   = (act && tgt_q == T_FB) ? off_q : 28'h0;
    assign fb_we_out     = issue_wr && tgt_q == T_FB && off_q != FB_SWAP_ADDR;
    assign fb_swap_out   = issue_wr && tgt_q == T_FB && off_q == FB_SWAP_ADDR;
    assign fb_wdata_out  = (act && tgt_q == T_FB) ? wdata_q[15:0] : 16'h0;

    assign io_addr_out   = (act && tgt_q == T_IO) ? off_q : 28'h0;
    assign io_we_out     = issue_wr && tgt_q == T_IO;
    assign io_wdata_out  = (act && tgt_q == T_IO) ? wdata_q : 32'h0;

endmodule

// File: tb/tb_mem_router.sv
// Two router instances (1-byte and 4-byte RAM ports) driven with directed and random requests;
// a byte-level reference model predicts responses and port strobes, monitors compare them.
module tb_mem_router;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          due;
    } rsp_t;

    typedef struct {
        int          kind;   // 0 RAM write, 1 FB write, 2 FB swap, 3 IO write
        logic [27:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } stb_t;

    localparam logic [27:0] SWAP = 28'h0000040;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int ndone  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [27:0] a);
        return 32'hC0DE_0000 ^ (32'({a[27:2], 2'b00}) * 32'h9E37_79B1);
    endfunction

    function automatic logic [15:0] fb_word(input logic [27:0] a);
        return a[15:0] ^ 16'hBEEF;
    endfunction

    function automatic logic [31:0] io_word(input logic [27:0] a);
        return (32'(a) * 32'h0100_0193) ^ 32'h0012_3456;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int RB   = (g == 0) ? 1 : 4;
        localparam int RAML = (g == 0) ? 2 : 0;
        localparam int ROML = (g == 0) ? 2 : 1;
        localparam int FBL  = (g == 0) ? 2 : 3;
        localparam int ABRT = (g == 0) ? 2 : 1;

        logic              rst_n;
        logic              req_valid, req_write, req_ready;
        logic [31:0]       req_addr, req_wdata;
        logic [1:0]        req_width;
        logic              rsp_valid, rsp_err;
        logic [31:0]       rsp_rdata;
        logic [27:0]       ram_addr, rom_addr, fb_addr, io_addr;
        logic              ram_we, fb_we, fb_swap, io_we;
        logic [RB-1:0]     ram_be;
        logic [8*RB-1:0]   ram_wdata, ram_rdata;
        logic [31:0]       rom_rdata, io_wdata, io_rdata;
        logic [15:0]       fb_wdata, fb_rdata;
        logic              mem_clr;
        logic [7:0]        dev_mem [0:1023];
        logic [7:0]        ref_mem [0:1023];
        rsp_t              rspq[$];
        stb_t              stbq[$];

        mem_router #(
            .RAM_BYTES(RB), .RAM_LAT(RAML), .ROM_LAT(ROML), .FB_LAT(FBL), .FB_SWAP_ADDR(SWAP)
        ) dut (
            .clk_in(clk), .rst_n_in(rst_n),
            .req_valid_in(req_valid), .req_ready_out(req_ready),
            .req_write_in(req_write), .req_addr_in(req_addr),
            .req_wdata_in(req_wdata), .req_width_in(req_width),
            .rsp_valid_out(rsp_valid), .rsp_rdata_out(rsp_rdata), .rsp_err_out(rsp_err),
            .ram_addr_out(ram_addr), .ram_we_out(ram_we), .ram_be_out(ram_be),
            .ram_wdata_out(ram_wdata), .ram_rdata_in(ram_rdata),
            .rom_addr_out(rom_addr), .rom_rdata_in(rom_rdata),
            .fb_addr_out(fb_addr), .fb_we_out(fb_we), .fb_swap_out(fb_swap),
            .fb_wdata_out(fb_wdata), .fb_rdata_in(fb_rdata),
            .io_addr_out(io_addr), .io_we_out(io_we), .io_wdata_out(io_wdata),
            .io_rdata_in(io_rdata)
        );

        // Peripheral models
        assign rom_rdata = rom_word(rom_addr);
        assign fb_rdata  = fb_word(fb_addr);
        assign io_rdata  = io_word(io_addr);

        always_comb begin
            ram_rdata = '0;
            for (int l = 0; l < RB; l++)
                ram_rdata[8*l +: 8] = dev_mem[(int'(ram_addr) * RB + l) & 1023];
        end

        always @(posedge clk) begin
            if (mem_clr) begin
                for (int i = 0; i < 1024; i++) dev_mem[i] <= 8'h00;
            end else if (ram_we) begin
                for (int l = 0; l < RB; l++)
                    if (ram_be[l]) dev_mem[(int'(ram_addr) * RB + l) & 1023] <= ram_wdata[8*l +: 8];
            end
        end

        // Reference model: byte-addressed memory plus the request rules.
        task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] wd, output rsp_t e);
            int          sz, tgt, beats, lat;
            logic [27:0] off;
            logic [31:0] m;
            sz    = 1 << wd;
            off   = a[27:0];
            tgt   = int'(a[29:28]);
            m     = (wd == 2'd0) ? 32'hFF : (wd == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
            beats = (tgt == 1 && sz > RB) ? sz / RB : 1;
            lat   = (tgt == 0) ? ROML : (tgt == 1) ? RAML : (tgt == 2) ? FBL : 0;
            e.rd  = 32'h0;
            e.err = (wd == 2'd3) || (a[31:30] != 2'b00) || ((int'(off) % sz) != 0)
                 || (w && tgt == 0) || (tgt == 2 && wd != 2'd1);
            if (e.err) begin
                e.due = cyc + 1;
            end else begin
                e.due = cyc + (w ? 1 + beats : 1 + beats * (1 + lat));
                case (tgt)
                    0: e.rd = (rom_word(off) >> (8 * int'(off[1:0]))) & m;
                    1: begin
                        if (w) begin
                            for (int i = 0; i < sz; i++) ref_mem[(int'(off) + i) & 1023] = d[8*i +: 8];
                            for (int k = 0; k < beats; k++) begin
                                stb_t        s;
                                logic [63:0] dd;
                                s.kind = 0;
                                s.addr = 28'(int'(off) / RB + k);
                                if (sz < RB) begin
                                    s.be = 4'(((1 << sz) - 1) << (int'(off) % RB));
                                    dd   = {32'h0, d} << (8 * (int'(off) % RB));
                                end else begin
                                    s.be = 4'((1 << RB) - 1);
                                    dd   = {32'h0, d} >> (8 * RB * k);
                                end
                                s.data = 32'(dd & ((64'd1 << (8 * RB)) - 64'd1));
                                stbq.push_back(s);
                            end
                        end else begin
                            for (int i = 0; i < sz; i++) e.rd[8*i +: 8] = ref_mem[(int'(off) + i) & 1023];
                        end
                    end
                    2: begin
                        if (w) stbq.push_back('{(off == SWAP) ? 2 : 1, off, {16'h0, d[15:0]}, 4'h0});
                        else   e.rd = {16'h0, fb_word(off)};
                    end
                    default: begin
                        if (w) stbq.push_back('{3, off, d, 4'h0});
                        else   e.rd = io_word(off) & m;
                    end
                endcase
            end
        endtask

        // Offer junk while busy (must be ignored), then present the real request when ready.
        task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] wd, input bit expect_rsp);
            rsp_t e;
            int   n = 0;
            while (!req_ready && n < 300) begin
                req_valid = 1'($urandom_range(0, 1));
                req_write = 1'($urandom_range(0, 1));
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_width = 2'($urandom_range(0, 3));
                @(posedge clk); #1;
                n++;
            end
            if (!req_ready) begin
                checks++; errors++;
                $display("FAIL ready_timeout inst %0d: req_ready_out still 0 after %0d cycles, required 1", g, n);
            end
            req_valid = 1'b1;
            req_write = w;
            req_addr  = a;
            req_wdata = d;
            req_width = wd;
            model(w, a, d, wd, e);
            if (expect_rsp) rspq.push_back(e);
            @(posedge clk); #1;
            req_valid = 1'b0;
        endtask

        always @(negedge clk) begin
            rsp_t e;
            stb_t o, x;
            int   ns;
            if (rsp_valid) begin
                if (rspq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected inst %0d: got rsp data %h err %b at cycle %0d, required no response",
                             g, rsp_rdata, rsp_err, cyc);
                end else begin
                    e = rspq.pop_front();
                    chk($sformatf("rsp_data inst %0d", g), rsp_rdata, e.rd);
                    chk($sformatf("rsp_err inst %0d", g), 32'(rsp_err), 32'(e.err));
                    chk($sformatf("rsp_cycle inst %0d", g), cyc, e.due);
                end
            end
            ns = int'(ram_we) + int'(fb_we) + int'(fb_swap) + int'(io_we);
            if (ns != 0) begin
                o.kind = ram_we ? 0 : fb_we ? 1 : fb_swap ? 2 : 3;
                o.addr = ram_we ? ram_addr : (fb_we || fb_swap) ? fb_addr : io_addr;
                o.data = ram_we ? 32'(ram_wdata) : (fb_we || fb_swap) ? {16'h0, fb_wdata} : io_wdata;
                o.be   = ram_we ? 4'(ram_be) : 4'h0;
                chk($sformatf("strobe_single inst %0d", g), ns, 1);
                if (stbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL strobe_unexpected inst %0d: got kind %0d addr %h data %h at cycle %0d, required none",
                             g, o.kind, o.addr, o.data, cyc);
                end else begin
                    x = stbq.pop_front();
                    chk($sformatf("strobe_kind inst %0d", g), o.kind, x.kind);
                    chk($sformatf("strobe_addr inst %0d", g), 32'(o.addr), 32'(x.addr));
                    chk($sformatf("strobe_data inst %0d", g), o.data, x.data);
                    chk($sformatf("strobe_be inst %0d", g), 32'(o.be), 32'(x.be));
                end
            end
        end

        task automatic check_quiet(input string nm);
            chk({nm, "_ready"}, 32'(req_ready), 32'h1);
            chk({nm, "_ctrl"}, {26'h0, rsp_valid, rsp_err, ram_we, fb_we, fb_swap, io_we}, 32'h0);
            chk({nm, "_addr"}, 32'(ram_addr | rom_addr | fb_addr | io_addr), 32'h0);
            chk({nm, "_data"}, rsp_rdata | 32'(ram_be) | 32'(ram_wdata) | io_wdata | {16'h0, fb_wdata}, 32'h0);
        endtask

        initial begin
            int n;
            rst_n     = 1'b1;
            mem_clr   = 1'b1;
            req_valid = 1'b0;
            req_write = 1'b0;
            req_addr  = 32'h0;
            req_wdata = 32'h0;
            req_width = 2'd0;
            for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
            #2 rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check_quiet($sformatf("reset inst %0d", g));
            mem_clr = 1'b0;
            rst_n   = 1'b1;
            @(posedge clk); #1;

            send(1'b1, 32'h1000_0010, 32'hA1B2_C3D4, 2'd2, 1'b1);
            send(1'b0, 32'h1000_0010, 32'h0,         2'd2, 1'b1);
            send(1'b1, 32'h1000_0003, 32'h0000_0055, 2'd0, 1'b1);
            send(1'b0, 32'h1000_0000, 32'h0,         2'd2, 1'b1);
            send(1'b0, 32'h1000_0002, 32'h0,         2'd1, 1'b1);
            send(1'b0, 32'h1000_0001, 32'h0,         2'd1, 1'b1);
            send(1'b1, 32'h0000_0004, 32'h1234_5678, 2'd2, 1'b1);
            send(1'b0, 32'h1000_0000, 32'h0,         2'd3, 1'b1);
            send(1'b1, 32'h2000_0040, 32'h0000_BEEF, 2'd1, 1'b1);
            send(1'b1, 32'h2000_0042, 32'h0000_1357, 2'd1, 1'b1);
            send(1'b0, 32'h3000_0000, 32'h0,         2'd2, 1'b1);
            send(1'b0, 32'h0000_0006, 32'h0,         2'd1, 1'b1);

            // Abort a RAM read mid-beat; it must never answer.
            send(1'b0, 32'h1000_0020, 32'h0, 2'd2, 1'b0);
            repeat (ABRT - 1) begin @(posedge clk); #1; end
            rst_n = 1'b0;
            #1;
            check_quiet($sformatf("abort inst %0d", g));
            @(posedge clk); #1;
            rst_n = 1'b1;
            send(1'b0, 32'h1000_0010, 32'h0, 2'd2, 1'b1);

            for (int i = 0; i < 250; i++) begin
                logic [31:0] a;
                logic [1:0]  wd;
                logic        w;
                w       = 1'($urandom_range(0, 1));
                wd      = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                a[31:30] = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                a[29:28] = 2'($urandom_range(0, 3));
                a[27:0]  = 28'($urandom_range(0, 255));
                if (a[29:28] == 2'd2 && $urandom_range(0, 3) != 0) wd = 2'd1;
                if (wd != 2'd3 && $urandom_range(0, 3) != 0) a[27:0] = a[27:0] & ~28'((1 << wd) - 1);
                if (a[29:28] == 2'd2 && $urandom_range(0, 5) == 0) a[27:0] = SWAP;
                send(w, a, $urandom, wd, 1'b1);
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end

            n = 0;
            while ((rspq.size() != 0 || !req_ready) && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            repeat (4) @(posedge clk);
            #1;
            chk($sformatf("rsp_queue_drained inst %0d", g), rspq.size(), 0);
            chk($sformatf("strobe_queue_drained inst %0d", g), stbq.size(), 0);
            ndone++;
        end
    end

    initial begin
        int n = 0;
        while (ndone < 2 && n < 50000) begin
            @(posedge clk);
            n++;
        end
        if (ndone < 2) begin
            checks++; errors++;
            $display("FAIL run_timeout: %0d of 2 instances finished, required 2", ndone);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
